// File: rtl/tmr_monitor_pkg.sv
// Shared types and arithmetic helpers for the TMR mismatch monitor.
package tmr_monitor_pkg;

    localparam int unsigned DEF_CNT_W = 16;
    // Widest counter and voter vector the helpers below support.
    localparam int unsigned CALC_W    = 32;
    localparam int unsigned POP_W     = 64;

    typedef enum logic {
        RUN     = 1'b0,
        CLR_ACK = 1'b1
    } clr_state_t;

    function automatic logic [7:0] popcount(input logic [POP_W-1:0] v);
        logic [7:0] c;
        c = '0;
        for (int unsigned i = 0; i < POP_W; i++) begin
            c = c + 8'(v[i]);
        end
        return c;
    endfunction

    // Add with saturation at max_val; one extra bit catches the carry.
    function automatic logic [CALC_W-1:0] sat_add(input logic [CALC_W-1:0] a,
                                                  input logic [CALC_W-1:0] b,
                                                  input logic [CALC_W-1:0] max_val);
        logic [CALC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[CALC_W-1:0];
    endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority over counting.
module tmr_sat_counter
    import tmr_monitor_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned INC_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = CNT_W'(sat_add(CALC_W'(cnt_q), CALC_W'(inc_i), CALC_W'(CNT_MAX)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tmr_mismatch_monitor.sv
// Collects voter mismatch edges into counters, sticky flags, first-error capture
// and a level interrupt; cleared through a four-phase req/ack handshake.
module tmr_mismatch_monitor
    import tmr_monitor_pkg::*;
#(
    parameter  int unsigned N_VOTERS = 8,
    parameter  int unsigned CNT_W    = DEF_CNT_W,
    localparam int unsigned IDX_W    = $clog2(N_VOTERS)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [N_VOTERS-1:0] mismatch_i,
    input  logic [N_VOTERS-1:0] mismatch_2nd_i,
    input  logic                irq_en_i,
    input  logic                clr_req_i,
    output logic                clr_ack_o,
    output logic [CNT_W-1:0]    event_cnt_o,
    output logic [CNT_W-1:0]    chk_fault_cnt_o,
    output logic [N_VOTERS-1:0] sticky_o,
    output logic [IDX_W-1:0]    first_idx_o,
    output logic                first_vld_o,
    output logic                irq_o
);

    localparam int unsigned INC_W = $clog2(N_VOTERS + 1);

    logic [N_VOTERS-1:0] s1_m_q, s1_m2_q, s2_m_q, s2_m2_q;
    logic [N_VOTERS-1:0] ev, cf, hit;
    logic [N_VOTERS-1:0] sticky_d, sticky_q;
    logic [IDX_W-1:0]    low_idx, first_idx_d, first_idx_q;
    logic                first_vld_d, first_vld_q;
    logic                ack_d, ack_q, irq_d, irq_q;
    logic                do_clr, do_upd;
    logic [INC_W-1:0]    inc_ev, inc_cf;
    clr_state_t          state_d, state_q;

    // Rising edges of "any mismatch" and of primary/secondary disagreement.
    assign ev  = (s1_m_q | s1_m2_q) & ~(s2_m_q | s2_m2_q);
    assign cf  = (s1_m_q ^ s1_m2_q) & ~(s2_m_q ^ s2_m2_q);
    assign hit = ev | cf;

    assign do_clr = (state_q == RUN) &&  clr_req_i;
    assign do_upd = (state_q == RUN) && !clr_req_i;

    assign inc_ev = INC_W'(popcount(POP_W'(ev)));
    assign inc_cf = INC_W'(popcount(POP_W'(cf)));

    always_comb begin
        low_idx = '0;
        for (int i = N_VOTERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        sticky_d    = sticky_q;
        first_idx_d = first_idx_q;
        first_vld_d = first_vld_q;
        irq_d       = irq_en_i & (|sticky_q);
        unique case (state_q)
            RUN: begin
                if (clr_req_i) begin
                    state_d     = CLR_ACK;
                    ack_d       = 1'b1;
                    sticky_d    = '0;
                    first_idx_d = '0;
                    first_vld_d = 1'b0;
                end else begin
                    sticky_d = sticky_q | hit;
                    if (!first_vld_q && (|hit)) begin
                        first_idx_d = low_idx;
                        first_vld_d = 1'b1;
                    end
                end
            end
            CLR_ACK: begin
                if (!clr_req_i) begin
                    state_d = RUN;
                    ack_d   = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            ack_q       <= 1'b0;
            sticky_q    <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            irq_q       <= 1'b0;
            s1_m_q      <= '0;
            s1_m2_q     <= '0;
            s2_m_q      <= '0;
            s2_m2_q     <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            sticky_q    <= sticky_d;
            first_idx_q <= first_idx_d;
            first_vld_q <= first_vld_d;
            irq_q       <= irq_d;
            s1_m_q      <= mismatch_i;
            s1_m2_q     <= mismatch_2nd_i;
            s2_m_q      <= s1_m_q;
            s2_m2_q     <= s1_m2_q;
        end
    end

    tmr_sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_ev_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (do_clr),
        .en_i    (do_upd),
        .inc_i   (inc_ev),
        .cnt_o   (event_cnt_o)
    );

    tmr_sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_cf_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (do_clr),
        .en_i    (do_upd),
        .inc_i   (inc_cf),
        .cnt_o   (chk_fault_cnt_o)
    );

    assign clr_ack_o   = ack_q;
    assign sticky_o    = sticky_q;
    assign first_idx_o = first_idx_q;
    assign first_vld_o = first_vld_q;
    assign irq_o       = irq_q;

    a_inputs_known: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !$isunknown({mismatch_i, mismatch_2nd_i, irq_en_i, clr_req_i}));

endmodule

// File: tb/tb_tmr_mismatch_monitor.sv
// Randomized and directed check of tmr_mismatch_monitor against a count-based model.
module tb_tmr_mismatch_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  m = '0, m2 = '0;
    logic        en = 1'b0, req = 1'b0;

    logic        ack, fvld, irq;
    logic [15:0] evc, cfc;
    logic [7:0]  sticky;
    logic [2:0]  fidx;

    logic        ack4, fvld4, irq4;
    logic [3:0]  evc4, cfc4;
    logic [7:0]  sticky4;
    logic [2:0]  fidx4;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: unbounded event totals, saturation applied on comparison.
    int         raw_ev, raw_cf;
    logic [7:0] p1_m, p1_m2, p2_m, p2_m2;
    logic [7:0] e_sticky;
    logic [2:0] e_fidx;
    logic       e_fvld, e_ack, e_irq, e_run;

    always #5 clk = ~clk;

    tmr_mismatch_monitor dut (
        .clk_i(clk), .rst_n_i(rst_n), .mismatch_i(m), .mismatch_2nd_i(m2),
        .irq_en_i(en), .clr_req_i(req), .clr_ack_o(ack), .event_cnt_o(evc),
        .chk_fault_cnt_o(cfc), .sticky_o(sticky), .first_idx_o(fidx),
        .first_vld_o(fvld), .irq_o(irq)
    );

    tmr_mismatch_monitor #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .mismatch_i(m), .mismatch_2nd_i(m2),
        .irq_en_i(en), .clr_req_i(req), .clr_ack_o(ack4), .event_cnt_o(evc4),
        .chk_fault_cnt_o(cfc4), .sticky_o(sticky4), .first_idx_o(fidx4),
        .first_vld_o(fvld4), .irq_o(irq4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int raw, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    task automatic model_reset();
        raw_ev = 0; raw_cf = 0;
        p1_m = '0; p1_m2 = '0; p2_m = '0; p2_m2 = '0;
        e_sticky = '0; e_fidx = '0; e_fvld = 1'b0;
        e_ack = 1'b0; e_irq = 1'b0; e_run = 1'b1;
    endtask

    // One clock edge as seen by the model, using the inputs sampled at that edge.
    task automatic model_edge();
        logic [7:0] ev, cf, hit;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ev  = (p1_m | p1_m2) & ~(p2_m | p2_m2);
        cf  = (p1_m ^ p1_m2) & ~(p2_m ^ p2_m2);
        hit = ev | cf;
        e_irq = en && (e_sticky != 0);
        if (e_run && req) begin
            raw_ev = 0; raw_cf = 0;
            e_sticky = '0; e_fidx = '0; e_fvld = 1'b0;
            e_ack = 1'b1; e_run = 1'b0;
        end else if (e_run) begin
            raw_ev += $countones(ev);
            raw_cf += $countones(cf);
            e_sticky |= hit;
            if (!e_fvld && hit != 0) begin
                e_fvld = 1'b1;
                for (int i = 7; i >= 0; i--) if (hit[i]) e_fidx = 3'(i);
            end
        end else if (!req) begin
            e_run = 1'b1;
            e_ack = 1'b0;
        end
        p2_m = p1_m; p2_m2 = p1_m2;
        p1_m = m;    p1_m2 = m2;
    endtask

    task automatic check_all();
        check("ack",      64'(ack),    64'(e_ack));
        check("evcnt",    64'(evc),    64'(sat(raw_ev, 16)));
        check("cfcnt",    64'(cfc),    64'(sat(raw_cf, 16)));
        check("sticky",   64'(sticky), 64'(e_sticky));
        check("fvld",     64'(fvld),   64'(e_fvld));
        check("fidx",     64'(fidx),   64'(e_fidx));
        check("irq",      64'(irq),    64'(e_irq));
        check("evcnt4",   64'(evc4),   64'(sat(raw_ev, 4)));
        check("cfcnt4",   64'(cfc4),   64'(sat(raw_cf, 4)));
        check("sticky4",  64'(sticky4), 64'(e_sticky));
    endtask

    task automatic apply(input logic [7:0] vm, input logic [7:0] vm2,
                         input logic ven, input logic vreq, input logic vrst_n);
        m = vm; m2 = vm2; en = ven; req = vreq; rst_n = vrst_n;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] rm, rm2;
        logic       ren, rreq, rrst;
        model_reset();

        // Reset with quiet inputs.
        repeat (3) apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) apply(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        check("rst_evcnt", 64'(evc), 64'd0);
        check("rst_ack",   64'(ack), 64'd0);
        check("rst_fvld",  64'(fvld), 64'd0);

        // Single persistent mismatch counts once.
        repeat (10) apply(8'h08, 8'h00, 1'b1, 1'b0, 1'b1);
        repeat (2)  apply(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t2_evcnt",  64'(evc),    64'd1);
        check("t2_sticky", 64'(sticky), 64'h08);
        check("t2_fidx",   64'(fidx),   64'd3);
        check("t2_irq",    64'(irq),    64'd1);

        // Clear, then two simultaneous edges with a disagreement on voter 2.
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (4) apply(8'h24, 8'h20, 1'b0, 1'b0, 1'b1);
        check("t3_evcnt", 64'(evc),  64'd2);
        check("t3_cfcnt", 64'(cfc),  64'd1);
        check("t3_fidx",  64'(fidx), 64'd2);
        repeat (2) apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // Pulse train: the 4-bit instance saturates at 15.
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            apply(8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
            apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        check("t4_evcnt4", 64'(evc4), 64'd15);
        check("t4_evcnt",  64'(evc),  64'd20);

        // Clear coincident with a new event on voter 1: event is dropped.
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        apply(8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
        apply(8'h02, 8'h00, 1'b0, 1'b1, 1'b1);
        check("t5_evcnt", 64'(evc),    64'd0);
        check("t5_stky",  64'(sticky), 64'd0);
        check("t5_fvld",  64'(fvld),   64'd0);
        check("t5_ack",   64'(ack),    64'd1);
        apply(8'hff, 8'h0f, 1'b0, 1'b1, 1'b1);
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        apply(8'hff, 8'h00, 1'b0, 1'b1, 1'b1);
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check("t5_hold",  64'(evc),    64'd0);
        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t5_ackdn", 64'(ack),    64'd0);
        apply(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        apply(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        check("t5_after", 64'(evc),    64'd1);

        // Reset in the middle of a handshake.
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("t6_ackrst", 64'(ack), 64'd0);
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check("t6_ackre",  64'(ack), 64'd1);
        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // Random traffic: sparse bit flips, occasional handshakes, rare resets.
        rm = '0; rm2 = '0; ren = 1'b1; rreq = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rm = rm ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            rm2 = ($urandom_range(3) == 0) ? (rm ^ (8'($urandom) & 8'($urandom))) : rm;
            if (rreq) rreq = ($urandom_range(3) != 0);
            else      rreq = ($urandom_range(39) == 0);
            if ($urandom_range(19) == 0) ren = ~ren;
            rrst = ($urandom_range(399) != 0);
            apply(rm, rm2, ren, rreq, rrst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
